// File: rtl/udma_ctrl_gen_if.sv
// uDMA configuration bus seen by the control register block.
// Word-addressed single-cycle accesses; read data is returned combinationally.
interface udma_ctrl_gen_if;
    logic [31:0] cfg_data_i;
    logic [4:0]  cfg_addr_i;
    logic        cfg_valid_i;
    logic        cfg_rwn_i;
    logic [31:0] cfg_data_o;
    logic        cfg_ready_o;

    modport master (
        output cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
        input  cfg_data_o, cfg_ready_o
    );

    modport slave (
        input  cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
        output cfg_data_o, cfg_ready_o
    );
endinterface

// File: rtl/udma_ctrl_gen.sv
// uDMA top-level control registers: peripheral clock gating and reset pulses,
// event comparators with sticky status, and the filter start/abort handshake.
module udma_ctrl_gen #(
    parameter int N_PERIPH    = 16,
    parameter int N_EVT_CMP   = 4,
    parameter int RST_CYCLES  = 4,
    parameter int FILT_MODE_W = 3
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    udma_ctrl_gen_if.slave         cfg,
    output logic [N_PERIPH-1:0]    cg_value_o,
    output logic                   cg_core_o,
    output logic [N_PERIPH-1:0]    rst_value_o,
    input  logic                   event_valid_i,
    input  logic [7:0]             event_data_i,
    output logic                   event_ready_o,
    output logic [N_EVT_CMP-1:0]   event_o,
    output logic                   evt_irq_o,
    output logic [FILT_MODE_W-1:0] cfg_filter_mode_o,
    output logic                   cfg_filter_start_o,
    input  logic                   cfg_filter_start_ready_i,
    output logic                   cfg_filter_abort_o,
    input  logic                   filter_busy_i,
    input  logic                   filter_done_i
);
    localparam logic [4:0] ADDR_CG       = 5'h00;
    localparam logic [4:0] ADDR_CG_SET   = 5'h01;
    localparam logic [4:0] ADDR_CG_CLR   = 5'h02;
    localparam logic [4:0] ADDR_RST      = 5'h03;
    localparam logic [4:0] ADDR_CMP0     = 5'h04;
    localparam logic [4:0] ADDR_CMP1     = 5'h05;
    localparam logic [4:0] ADDR_EVT_STAT = 5'h06;
    localparam logic [4:0] ADDR_EVT_EN   = 5'h07;
    localparam logic [4:0] ADDR_IRQ_EN   = 5'h08;
    localparam logic [4:0] ADDR_FMODE    = 5'h09;
    localparam logic [4:0] ADDR_FCMD     = 5'h0A;
    localparam logic [4:0] ADDR_FSTAT    = 5'h0B;
    localparam logic [4:0] ADDR_ID       = 5'h1F;
    localparam logic [N_PERIPH-1:0] P_ZERO = {N_PERIPH{1'b0}};

    typedef enum logic [0:0] {FS_IDLE = 1'b0, FS_PEND = 1'b1} filt_state_e;

    logic                   wr_s, rd_s;
    logic [N_PERIPH-1:0]    pdata_s;
    logic [N_EVT_CMP-1:0]   edata_s;
    logic                   start_wr_s, abort_wr_s, done_clr_s;
    logic [N_PERIPH-1:0]    cg_r, rst_mask_r;
    logic [7:0]             cmp_r [N_EVT_CMP];
    logic [31:0]            cmp_word_s [2];
    logic [N_EVT_CMP-1:0]   evt_en_r, irq_en_r, evt_stat_r, event_s;
    logic [FILT_MODE_W-1:0] fmode_r;
    filt_state_e            filt_state_r, filt_state_s;
    logic                   start_pending_s, abort_r, done_sticky_r;
    logic [31:0]            rdata_s;

    assign wr_s       = cfg.cfg_valid_i & ~cfg.cfg_rwn_i;
    assign rd_s       = cfg.cfg_valid_i & cfg.cfg_rwn_i;
    assign pdata_s    = cfg.cfg_data_i[N_PERIPH-1:0];
    assign edata_s    = cfg.cfg_data_i[N_EVT_CMP-1:0];
    assign start_wr_s = wr_s & (cfg.cfg_addr_i == ADDR_FCMD) & cfg.cfg_data_i[0];
    assign abort_wr_s = wr_s & (cfg.cfg_addr_i == ADDR_FCMD) & cfg.cfg_data_i[1];
    assign done_clr_s = wr_s & (cfg.cfg_addr_i == ADDR_FSTAT) & cfg.cfg_data_i[2];

    // Clock-enable register with atomic set/clear aliases
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                                            cg_r <= P_ZERO;
        else if (wr_s && (cfg.cfg_addr_i == ADDR_CG))           cg_r <= pdata_s;
        else if (wr_s && (cfg.cfg_addr_i == ADDR_CG_SET))       cg_r <= cg_r | pdata_s;
        else if (wr_s && (cfg.cfg_addr_i == ADDR_CG_CLR))       cg_r <= cg_r & ~pdata_s;
    end

    generate
        if (RST_CYCLES > 0) begin : g_rst_pulse
            localparam int CNT_W = $clog2(RST_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_CYCLES);
            localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
            localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
            logic [CNT_W-1:0] rst_cnt_r;

            // Retrigger extends every active bit; mask drops on the counter's 1->0 step
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    rst_mask_r <= P_ZERO;
                    rst_cnt_r  <= CNT_ZERO;
                end else if (wr_s && (cfg.cfg_addr_i == ADDR_RST) && (pdata_s != P_ZERO)) begin
                    rst_mask_r <= rst_mask_r | pdata_s;
                    rst_cnt_r  <= CNT_LOAD;
                end else if (rst_cnt_r != CNT_ZERO) begin
                    rst_cnt_r <= rst_cnt_r - CNT_ONE;
                    if (rst_cnt_r == CNT_ONE) rst_mask_r <= P_ZERO;
                end
            end
        end else begin : g_rst_level
            // Legacy level mode: register drives the resets directly
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i)                                  rst_mask_r <= P_ZERO;
                else if (wr_s && (cfg.cfg_addr_i == ADDR_RST)) rst_mask_r <= pdata_s;
            end
        end
    endgenerate

    // Comparator ids, four per word; ids 4..7 live in the second word
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < N_EVT_CMP; i++) cmp_r[i] <= 8'h00;
        end else begin
            for (int i = 0; i < N_EVT_CMP; i++)
                if (wr_s && (cfg.cfg_addr_i == ((i < 4) ? ADDR_CMP0 : ADDR_CMP1)))
                    cmp_r[i] <= cfg.cfg_data_i[8*(i%4) +: 8];
        end
    end

    // Event enables, interrupt enables and filter mode
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            evt_en_r <= {N_EVT_CMP{1'b0}};
            irq_en_r <= {N_EVT_CMP{1'b0}};
            fmode_r  <= {FILT_MODE_W{1'b0}};
        end else if (wr_s) begin
            if (cfg.cfg_addr_i == ADDR_EVT_EN) evt_en_r <= edata_s;
            if (cfg.cfg_addr_i == ADDR_IRQ_EN) irq_en_r <= edata_s;
            if (cfg.cfg_addr_i == ADDR_FMODE)  fmode_r  <= cfg.cfg_data_i[FILT_MODE_W-1:0];
        end
    end

    // Per-comparator match, several may fire together
    always_comb begin
        event_s = {N_EVT_CMP{1'b0}};
        for (int i = 0; i < N_EVT_CMP; i++)
            event_s[i] = event_valid_i & evt_en_r[i] & (event_data_i == cmp_r[i]);
    end

    // Sticky status: a new hit overrides a concurrent W1C
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                                        evt_stat_r <= {N_EVT_CMP{1'b0}};
        else if (wr_s && (cfg.cfg_addr_i == ADDR_EVT_STAT)) evt_stat_r <= (evt_stat_r & ~edata_s) | event_s;
        else                                                evt_stat_r <= evt_stat_r | event_s;
    end

    // Filter start state register, abort pulse and done sticky bit
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            filt_state_r  <= FS_IDLE;
            abort_r       <= 1'b0;
            done_sticky_r <= 1'b0;
        end else begin
            filt_state_r  <= filt_state_s;
            abort_r       <= abort_wr_s;
            done_sticky_r <= filter_done_i | (done_sticky_r & ~done_clr_s);
        end
    end

    // Filter start next state: abort beats start, starts while pending are dropped
    always_comb begin
        filt_state_s = filt_state_r;
        case (filt_state_r)
            FS_IDLE: if (start_wr_s && !abort_wr_s) filt_state_s = FS_PEND;
                     else                           filt_state_s = FS_IDLE;
            FS_PEND: if (abort_wr_s || cfg_filter_start_ready_i) filt_state_s = FS_IDLE;
                     else                                         filt_state_s = FS_PEND;
            default: filt_state_s = FS_IDLE;
        endcase
    end

    // Filter start outputs
    always_comb begin
        start_pending_s = 1'b0;
        case (filt_state_r)
            FS_PEND: start_pending_s = 1'b1;
            default: start_pending_s = 1'b0;
        endcase
    end

    // Pack comparator ids into their register words
    always_comb begin
        cmp_word_s[0] = 32'h0000_0000;
        cmp_word_s[1] = 32'h0000_0000;
        for (int i = 0; i < N_EVT_CMP; i++) cmp_word_s[i/4][8*(i%4) +: 8] = cmp_r[i];
    end

    // Read mux; write-only aliases and unmapped addresses return 0
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (rd_s) begin
            case (cfg.cfg_addr_i)
                ADDR_CG:       rdata_s = 32'(cg_r);
                ADDR_RST:      rdata_s = 32'(rst_mask_r);
                ADDR_CMP0:     rdata_s = cmp_word_s[0];
                ADDR_CMP1:     rdata_s = cmp_word_s[1];
                ADDR_EVT_STAT: rdata_s = 32'(evt_stat_r);
                ADDR_EVT_EN:   rdata_s = 32'(evt_en_r);
                ADDR_IRQ_EN:   rdata_s = 32'(irq_en_r);
                ADDR_FMODE:    rdata_s = 32'(fmode_r);
                ADDR_FSTAT:    rdata_s = {29'd0, done_sticky_r, filter_busy_i, start_pending_s};
                ADDR_ID:       rdata_s = {8'h02, 8'(N_EVT_CMP), 8'h00, 8'(N_PERIPH)};
                default:       rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign cfg.cfg_data_o         = rdata_s;
    assign cfg.cfg_ready_o        = 1'b1;
    assign cg_value_o             = cg_r;
    assign cg_core_o              = |cg_r;
    assign rst_value_o            = rst_mask_r;
    assign event_ready_o          = 1'b1;
    assign event_o                = event_s;
    assign evt_irq_o              = |(evt_stat_r & irq_en_r);
    assign cfg_filter_mode_o      = fmode_r;
    assign cfg_filter_start_o     = start_pending_s;
    assign cfg_filter_abort_o     = abort_r;
endmodule

// File: tb/tb_udma_ctrl_gen.sv
// Scoreboard bench for udma_ctrl_gen: directed test-plan sequences plus random
// traffic, checked against a rule-level reference model.
module tb_udma_ctrl_gen;
    localparam int NP = 16, NE = 4, RC = 4, FW = 3;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    udma_ctrl_gen_if cfg_bus();
    logic [NP-1:0] cg_value, rst_value;
    logic          cg_core, ev_valid, ev_ready, evt_irq, fstart, fready, fabort, fbusy, fdone;
    logic [7:0]    ev_data;
    logic [NE-1:0] event_out;
    logic [FW-1:0] fmode;

    udma_ctrl_gen #(.N_PERIPH(NP), .N_EVT_CMP(NE), .RST_CYCLES(RC), .FILT_MODE_W(FW)) dut (
        .clk_i(clk), .rstn_i(rstn), .cfg(cfg_bus),
        .cg_value_o(cg_value), .cg_core_o(cg_core), .rst_value_o(rst_value),
        .event_valid_i(ev_valid), .event_data_i(ev_data), .event_ready_o(ev_ready),
        .event_o(event_out), .evt_irq_o(evt_irq), .cfg_filter_mode_o(fmode),
        .cfg_filter_start_o(fstart), .cfg_filter_start_ready_i(fready),
        .cfg_filter_abort_o(fabort), .filter_busy_i(fbusy), .filter_done_i(fdone)
    );

    int n_cmp = 0, n_fail = 0, cyc = 0;
    bit mon_en = 1'b0;
    logic [31:0] rd_q[$];

    // reference model state
    logic [NP-1:0] m_cg, m_rst;
    int            m_rst_until;
    logic [7:0]    m_cmp [NE];
    logic [NE-1:0] m_en, m_irq_en, m_stat;
    logic [FW-1:0] m_mode;
    bit            m_pend, m_abort, m_done;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_cg = '0; m_rst = '0; m_rst_until = 0; m_en = '0; m_irq_en = '0; m_stat = '0;
        m_mode = '0; m_pend = 0; m_abort = 0; m_done = 0;
        for (int i = 0; i < NE; i++) m_cmp[i] = 8'h00;
    endfunction

    function automatic logic [NE-1:0] exp_hits();
        logic [NE-1:0] h = '0;
        for (int i = 0; i < NE; i++) h[i] = ev_valid && m_en[i] && (ev_data == m_cmp[i]);
        return h;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'h00: return 32'(m_cg);
            5'h03: return 32'(m_rst);
            5'h04: return {m_cmp[3], m_cmp[2], m_cmp[1], m_cmp[0]};
            5'h06: return 32'(m_stat);
            5'h07: return 32'(m_en);
            5'h08: return 32'(m_irq_en);
            5'h09: return 32'(m_mode);
            5'h0B: return {29'd0, m_done, fbusy, m_pend};
            5'h1F: return 32'h0204_0010;
            default: return 32'h0;
        endcase
    endfunction

    // Apply the rules for one clock edge using the inputs held during that cycle.
    function automatic void model_edge();
        bit            w = cfg_bus.cfg_valid_i && !cfg_bus.cfg_rwn_i;
        logic [4:0]    a = cfg_bus.cfg_addr_i;
        logic [31:0]   d = cfg_bus.cfg_data_i;
        logic [NE-1:0] hits = exp_hits();
        bit            was_pend = m_pend;
        bit            rst_trig = w && (a == 5'h03) && (d[NP-1:0] != '0);
        m_abort = 0;
        if (was_pend && fready) m_pend = 0;
        if (rst_trig) begin
            m_rst = m_rst | d[NP-1:0];
            m_rst_until = cyc + RC;
        end else if (cyc >= m_rst_until) begin
            m_rst = '0;
        end
        if (w) begin
            case (a)
                5'h00: m_cg = d[NP-1:0];
                5'h01: m_cg = m_cg | d[NP-1:0];
                5'h02: m_cg = m_cg & ~d[NP-1:0];
                5'h04: for (int i = 0; i < NE; i++) m_cmp[i] = d[8*i +: 8];
                5'h06: m_stat = m_stat & ~d[NE-1:0];
                5'h07: m_en = d[NE-1:0];
                5'h08: m_irq_en = d[NE-1:0];
                5'h09: m_mode = d[FW-1:0];
                5'h0A: begin
                    if (d[1]) begin m_abort = 1; m_pend = 0; end
                    else if (d[0] && !was_pend) m_pend = 1;
                end
                5'h0B: if (d[2]) m_done = 0;
                default: ;
            endcase
        end
        m_stat = m_stat | hits;
        if (fdone) m_done = 1;
    endfunction

    task automatic step();
        @(posedge clk);
        if (rstn) begin
            cyc++;
            model_edge();
        end
        #1;
        cfg_bus.cfg_valid_i = 1'b0;
        ev_valid = 1'b0;
        fdone = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cfg_bus.cfg_valid_i = 1'b1; cfg_bus.cfg_rwn_i = 1'b0;
        cfg_bus.cfg_addr_i = a; cfg_bus.cfg_data_i = d;
        step();
    endtask

    task automatic rd(input logic [4:0] a);
        cfg_bus.cfg_valid_i = 1'b1; cfg_bus.cfg_rwn_i = 1'b1;
        cfg_bus.cfg_addr_i = a; cfg_bus.cfg_data_i = $urandom;
        rd_q.push_back(model_read(a));
        step();
    endtask

    // Monitor: pops expected read data when a read is presented, checks outputs every cycle
    always @(negedge clk) begin
        if (mon_en) begin
            if (cfg_bus.cfg_valid_i && cfg_bus.cfg_rwn_i) begin
                if (rd_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL rd_queue: read seen with no expected entry at t=%0t", $time);
                end else begin
                    chk("cfg_data_o", cfg_bus.cfg_data_o, rd_q.pop_front());
                end
            end
            chk("cg_value_o", 32'(cg_value), 32'(m_cg));
            chk("cg_core_o", 32'(cg_core), 32'(|m_cg));
            chk("rst_value_o", 32'(rst_value), 32'(m_rst));
            chk("event_o", 32'(event_out), 32'(exp_hits()));
            chk("evt_irq_o", 32'(evt_irq), 32'(|(m_stat & m_irq_en)));
            chk("filter_start_o", 32'(fstart), 32'(m_pend));
            chk("filter_abort_o", 32'(fabort), 32'(m_abort));
            chk("filter_mode_o", 32'(fmode), 32'(m_mode));
            chk("cfg_ready_o", 32'(cfg_bus.cfg_ready_o), 32'd1);
            chk("event_ready_o", 32'(ev_ready), 32'd1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [4:0] waddrs [15] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                                   5'h08, 5'h09, 5'h0A, 5'h0B, 5'h1F, 5'h0C, 5'h14};
        cfg_bus.cfg_valid_i = 1'b0; cfg_bus.cfg_rwn_i = 1'b1;
        cfg_bus.cfg_addr_i = 5'h00; cfg_bus.cfg_data_i = 32'h0;
        ev_valid = 1'b0; ev_data = 8'h00; fready = 1'b0; fbusy = 1'b0; fdone = 1'b0;
        model_reset();
        #2 rstn = 1'b0;
        #1 mon_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        // reset values and ID
        for (int a = 0; a <= 11; a++) rd(5'(a));
        rd(5'h1F);

        // clock gating aliases
        wr(5'h00, 32'h5); wr(5'h01, 32'h2); wr(5'h02, 32'h1); rd(5'h01); rd(5'h02);
        wr(5'h02, 32'h6); rd(5'h00);

        // reset pulse, retrigger, write of zero
        wr(5'h03, 32'h3); step(); wr(5'h03, 32'h4); rd(5'h03);
        repeat (5) step();
        wr(5'h03, 32'h1); wr(5'h03, 32'h0); rd(5'h03);
        repeat (4) step();

        // event comparators
        wr(5'h04, 32'h4433_2211); wr(5'h07, 32'h5); wr(5'h08, 32'h4);
        ev_valid = 1'b1; ev_data = 8'h33; step(); rd(5'h06);
        ev_valid = 1'b1; ev_data = 8'h22; step();
        ev_valid = 1'b1; ev_data = 8'h33; wr(5'h06, 32'h4); rd(5'h06);
        wr(5'h06, 32'h4); rd(5'h06); rd(5'h04); rd(5'h05);

        // filter start handshake, ignored restart, start+abort
        wr(5'h09, 32'h5);
        fready = 1'b0; wr(5'h0A, 32'h1); rd(5'h0B); step();
        fready = 1'b1; step(); fready = 1'b0; rd(5'h0B);
        wr(5'h0A, 32'h1); wr(5'h0A, 32'h1); fready = 1'b1; step(); fready = 1'b0; step();
        wr(5'h0A, 32'h3); rd(5'h0B); step();
        fready = 1'b1; wr(5'h0A, 32'h1); fready = 1'b0; step();

        // done sticky
        fdone = 1'b1; step(); rd(5'h0B);
        fdone = 1'b1; wr(5'h0B, 32'h4); rd(5'h0B);
        wr(5'h0B, 32'h4); fbusy = 1'b1; rd(5'h0B); fbusy = 1'b0;

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            int op = $urandom_range(0, 9);
            fready = ($urandom_range(0, 3) == 0);
            fbusy = 1'($urandom);
            fdone = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 2) == 0) begin
                ev_valid = 1'b1;
                ev_data = ($urandom_range(0, 1) == 1) ? m_cmp[$urandom_range(0, NE-1)] : 8'($urandom);
            end
            if (op <= 5) begin
                logic [4:0] a = waddrs[$urandom_range(0, 14)];
                logic [31:0] d = $urandom;
                if (a == 5'h03) d = d & 32'h0000_FFFF;
                if (a == 5'h03 && $urandom_range(0, 3) == 0) d = 32'h0;
                wr(a, d);
            end else if (op <= 8) begin
                rd(5'($urandom));
            end else begin
                step();
            end
        end
        fready = 1'b0; fbusy = 1'b0;
        repeat (6) step();

        // asynchronous reset while a start is pending
        wr(5'h03, 32'h00F0); wr(5'h0A, 32'h1);
        #2 rstn = 1'b0; model_reset();
        #1;
        chk("start_o_async_rst", 32'(fstart), 32'd0);
        chk("rst_value_async_rst", 32'(rst_value), 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        step();
        rd(5'h03); rd(5'h06); rd(5'h0B); rd(5'h00);
        step();

        mon_en = 1'b0;
        n_cmp++;
        if (rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL rd_queue_drain: %0d expected reads left, required 0", rd_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
